// File: rtl/cvxif_dotp_copro.sv
// cvxif_dotp_copro: CV-X-IF coprocessor computing packed signed int8 dot
// products (DOTP4), an accumulating variant (DOTP4ACC) and an accumulator
// clear (ACCCLR). Two-stage pipeline (products, then adder tree plus
// accumulator) feeding an in-order result FIFO of DEPTH entries.
module cvxif_dotp_copro #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ID_WIDTH = 3,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                issue_valid_i,
  output logic                issue_ready_o,
  input  logic [31:0]         issue_instr_i,
  input  logic [XLEN-1:0]     issue_rs1_i,
  input  logic [XLEN-1:0]     issue_rs2_i,
  input  logic [ID_WIDTH-1:0] issue_id_i,
  output logic                issue_accept_o,
  output logic                issue_writeback_o,
  output logic                result_valid_o,
  input  logic                result_ready_i,
  output logic [XLEN-1:0]     result_data_o,
  output logic [ID_WIDTH-1:0] result_id_o,
  output logic [4:0]          result_rd_o,
  output logic                result_we_o
);

  localparam int unsigned    PW          = $clog2(DEPTH);
  localparam int unsigned    CW          = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]  DEPTH_C     = CW'(DEPTH);
  localparam logic [PW-1:0]  LAST_PTR    = PW'(DEPTH - 1);
  localparam logic [6:0]     OPC_CUSTOM0 = 7'b0001011;

  typedef enum logic [1:0] {
    OP_DOTP    = 2'd0,
    OP_DOTPACC = 2'd1,
    OP_ACCCLR  = 2'd2
  } op_e;

  // Pointer advance with wrap at DEPTH (DEPTH need not be a power of two)
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // ---------------------------------------------------------------------
  // Decode and issue handshake
  // ---------------------------------------------------------------------
  logic       dec_ok;
  op_e        dec_op;
  logic       res_pop;
  logic       issue_take;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] fcnt_q;
  logic [9:0] unused_instr;

  // Recognise custom-0 opcode, funct7=0 and the three funct3 values
  always_comb begin
    dec_ok = 1'b0;
    dec_op = OP_DOTP;
    if (issue_instr_i[6:0] == OPC_CUSTOM0 && issue_instr_i[31:25] == 7'b0000000) begin
      case (issue_instr_i[14:12])
        3'b000:  begin dec_ok = 1'b1; dec_op = OP_DOTP;    end
        3'b001:  begin dec_ok = 1'b1; dec_op = OP_DOTPACC; end
        3'b010:  begin dec_ok = 1'b1; dec_op = OP_ACCCLR;  end
        default: dec_ok = 1'b0;
      endcase
    end
  end

  // rs1/rs2 register-index fields are irrelevant: operand values arrive on ports
  assign unused_instr = issue_instr_i[24:15];

  assign issue_accept_o    = issue_valid_i & dec_ok;
  assign issue_writeback_o = issue_accept_o;
  assign res_pop           = result_valid_o & result_ready_i;
  // A slot freed by a same-cycle result transfer may be reused immediately
  assign issue_ready_o     = ~rst_i & ((cnt_q < DEPTH_C) | res_pop);
  // Unrecognised instructions complete the handshake but are otherwise dropped
  assign issue_take        = issue_valid_i & issue_ready_o & dec_ok;

  // ---------------------------------------------------------------------
  // Stage S1: four signed 8x8 products
  // ---------------------------------------------------------------------
  logic signed [15:0]  prod_d [4];
  logic                s1_valid_q;
  logic signed [15:0]  s1_prod_q [4];
  logic [ID_WIDTH-1:0] s1_id_q;
  logic [4:0]          s1_rd_q;
  op_e                 s1_op_q;

  // Byte-lane signed products of the operands
  always_comb begin
    for (int unsigned k = 0; k < 4; k++) begin
      prod_d[k] = $signed(issue_rs1_i[8*k +: 8]) * $signed(issue_rs2_i[8*k +: 8]);
    end
  end

  // S1 register: products plus transaction tag, loaded on accepted issue
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_id_q    <= '0;
      s1_rd_q    <= '0;
      s1_op_q    <= OP_DOTP;
      for (int unsigned k = 0; k < 4; k++) begin
        s1_prod_q[k] <= '0;
      end
    end else begin
      s1_valid_q <= issue_take;
      if (issue_take) begin
        s1_id_q <= issue_id_i;
        s1_rd_q <= issue_instr_i[11:7];
        s1_op_q <= dec_op;
        for (int unsigned k = 0; k < 4; k++) begin
          s1_prod_q[k] <= prod_d[k];
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage S2: adder tree, accumulator update, FIFO write
  // ---------------------------------------------------------------------
  logic [XLEN-1:0] s2_sum;
  logic [XLEN-1:0] s2_wdata;
  logic [XLEN-1:0] acc_d;
  logic [XLEN-1:0] acc_q;

  // Sign-extended sum of the products and the op-dependent result/acc
  always_comb begin
    s2_sum = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      s2_sum = s2_sum + {{(XLEN-16){s1_prod_q[k][15]}}, s1_prod_q[k]};
    end
    acc_d    = acc_q;
    s2_wdata = s2_sum;
    if (s1_valid_q) begin
      case (s1_op_q)
        OP_DOTPACC: begin
          acc_d    = acc_q + s2_sum;
          s2_wdata = acc_q + s2_sum;
        end
        OP_ACCCLR: begin
          acc_d    = '0;
          s2_wdata = '0;
        end
        default: s2_wdata = s2_sum;
      endcase
    end
  end

  // Accumulator register, touched only by S2 so back-to-back ACC ops chain
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  // ---------------------------------------------------------------------
  // Result FIFO
  // ---------------------------------------------------------------------
  logic [XLEN-1:0]     fifo_data_q [DEPTH];
  logic [ID_WIDTH-1:0] fifo_id_q   [DEPTH];
  logic [4:0]          fifo_rd_q   [DEPTH];
  logic [PW-1:0]       wptr_q;
  logic [PW-1:0]       rptr_q;

  // FIFO storage written by S2; never overflows because cnt gates issue
  always_ff @(posedge clk_i) begin
    if (s1_valid_q) begin
      fifo_data_q[wptr_q] <= s2_wdata;
      fifo_id_q[wptr_q]   <= s1_id_q;
      fifo_rd_q[wptr_q]   <= s1_rd_q;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      fcnt_q <= '0;
    end else begin
      if (s1_valid_q) wptr_q <= ptr_inc(wptr_q);
      if (res_pop)    rptr_q <= ptr_inc(rptr_q);
      case ({s1_valid_q, res_pop})
        2'b10:   fcnt_q <= fcnt_q + CW'(1);
        2'b01:   fcnt_q <= fcnt_q - CW'(1);
        default: fcnt_q <= fcnt_q;
      endcase
    end
  end

  // In-flight count covering S1, S2 and the FIFO
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      case ({issue_take, res_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Head-of-FIFO outputs, forced to zero while empty; entries stay put until popped
  assign result_valid_o = (fcnt_q != '0);
  assign result_data_o  = result_valid_o ? fifo_data_q[rptr_q] : '0;
  assign result_id_o    = result_valid_o ? fifo_id_q[rptr_q]   : '0;
  assign result_rd_o    = result_valid_o ? fifo_rd_q[rptr_q]   : '0;
  assign result_we_o    = result_valid_o & (fifo_rd_q[rptr_q] != 5'd0);

  // In-flight accounting must never exceed the FIFO capacity
  cnt_bound_a: assert property (@(posedge clk_i) disable iff (rst_i) cnt_q <= DEPTH_C);

endmodule

// File: tb/tb_cvxif_dotp_copro.sv
// tb_cvxif_dotp_copro: table-driven vectors plus hand sequences for latency,
// back-pressure and mid-operation reset; results checked through a scoreboard.
module tb_cvxif_dotp_copro;

  localparam logic [2:0] F_DOTP = 3'b000;
  localparam logic [2:0] F_ACC  = 3'b001;
  localparam logic [2:0] F_CLR  = 3'b010;
  localparam int NV = 16;

  logic        clk;
  logic        rst_i;
  logic        issue_valid_i;
  logic        issue_ready_o;
  logic [31:0] issue_instr_i;
  logic [31:0] issue_rs1_i;
  logic [31:0] issue_rs2_i;
  logic [2:0]  issue_id_i;
  logic        issue_accept_o;
  logic        issue_writeback_o;
  logic        result_valid_o;
  logic        result_ready_i;
  logic [31:0] result_data_o;
  logic [2:0]  result_id_o;
  logic [4:0]  result_rd_o;
  logic        result_we_o;

  cvxif_dotp_copro #(
    .XLEN(32),
    .ID_WIDTH(3),
    .DEPTH(4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .issue_valid_i(issue_valid_i),
    .issue_ready_o(issue_ready_o),
    .issue_instr_i(issue_instr_i),
    .issue_rs1_i(issue_rs1_i),
    .issue_rs2_i(issue_rs2_i),
    .issue_id_i(issue_id_i),
    .issue_accept_o(issue_accept_o),
    .issue_writeback_o(issue_writeback_o),
    .result_valid_o(result_valid_o),
    .result_ready_i(result_ready_i),
    .result_data_o(result_data_o),
    .result_id_o(result_id_o),
    .result_rd_o(result_rd_o),
    .result_we_o(result_we_o)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [2:0]  id;
    logic        acc;
    logic [31:0] data;
    logic        consec;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  id;
    logic [4:0]  rd;
    logic        we;
    logic        consec;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   last_pop = 0;
  exp_t sbq[$];
  vec_t vt [NV];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "simulation timeout");
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd);
    return {7'b0000000, 10'b0, f3, rd, 7'b0001011};
  endfunction

  function automatic logic [31:0] dotp(input logic [31:0] a, input logic [31:0] b);
    int s;
    logic signed [7:0] x;
    logic signed [7:0] y;
    s = 0;
    for (int k = 0; k < 4; k++) begin
      x = a[8*k +: 8];
      y = b[8*k +: 8];
      s += int'(x) * int'(y);
    end
    return 32'(s);
  endfunction

  // Called just after a rising edge; returns just after the handshake edge
  task automatic drive_issue(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2,
                             input logic [2:0] id, input logic exp_acc, input logic [31:0] exp_data,
                             input logic consec, input string tag);
    int   waited;
    exp_t e;
    waited = 0;
    issue_valid_i = 1'b1;
    issue_instr_i = instr;
    issue_rs1_i   = rs1;
    issue_rs2_i   = rs2;
    issue_id_i    = id;
    @(negedge clk);
    while (!issue_ready_o && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, "_ready"}, 32'(issue_ready_o), 32'd1);
    chk({tag, "_accept"}, 32'(issue_accept_o), 32'(exp_acc));
    chk({tag, "_wb"}, 32'(issue_writeback_o), 32'(exp_acc));
    if (exp_acc) begin
      e.data   = exp_data;
      e.id     = id;
      e.rd     = instr[11:7];
      e.we     = (instr[11:7] != 5'd0);
      e.consec = consec;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    issue_valid_i = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while ((sbq.size() != 0 || result_valid_o) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drain"}, 32'(sbq.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: compares FIFO head every cycle, pops on transfer
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_i) begin
        if (sbq.size() == 0) begin
          chk("spurious_valid", 32'(result_valid_o), 32'd0);
        end else if (result_valid_o) begin
          e = sbq[0];
          chk("res_data", result_data_o, e.data);
          chk("res_id", 32'(result_id_o), 32'(e.id));
          chk("res_rd", 32'(result_rd_o), 32'(e.rd));
          chk("res_we", 32'(result_we_o), 32'(e.we));
          if (result_ready_i) begin
            if (e.consec) chk("res_gap", 32'(cyc - last_pop), 32'd1);
            last_pop = cyc;
            void'(sbq.pop_front());
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] a5;
    logic [31:0] b5;

    rst_i          = 1'b1;
    issue_valid_i  = 1'b0;
    issue_instr_i  = '0;
    issue_rs1_i    = '0;
    issue_rs2_i    = '0;
    issue_id_i     = '0;
    result_ready_i = 1'b0;

    vt[0]  = '{mk(F_DOTP, 5'd5),  32'h01020304, 32'h01010101, 3'd2, 1'b1, 32'h0000000A, 1'b0};
    vt[1]  = '{mk(F_DOTP, 5'd7),  32'hFF807F01, 32'h01020304, 3'd3, 1'b1, 32'h00000080, 1'b1};
    vt[2]  = '{mk(F_DOTP, 5'd0),  32'hFF807F01, 32'h01020304, 3'd4, 1'b1, 32'h00000080, 1'b1};
    vt[3]  = '{mk(F_ACC,  5'd1),  32'h01020304, 32'h01010101, 3'd5, 1'b1, 32'h0000000A, 1'b1};
    vt[4]  = '{mk(F_CLR,  5'd1),  32'hFFFFFFFF, 32'hFFFFFFFF, 3'd6, 1'b1, 32'h00000000, 1'b1};
    vt[5]  = '{mk(F_ACC,  5'd2),  32'h01020304, 32'h01010101, 3'd7, 1'b1, 32'h0000000A, 1'b1};
    vt[6]  = '{mk(F_ACC,  5'd3),  32'h01020304, 32'h01010101, 3'd0, 1'b1, 32'h00000014, 1'b1};
    vt[7]  = '{mk(F_ACC,  5'd4),  32'h01020304, 32'h01010101, 3'd1, 1'b1, 32'h0000001E, 1'b1};
    vt[8]  = '{32'h00000033,      32'h01020304, 32'h01010101, 3'd2, 1'b0, 32'h00000000, 1'b0};
    vt[9]  = '{mk(F_ACC,  5'd5),  32'hFF807F01, 32'h01020304, 3'd3, 1'b1, 32'h0000009E, 1'b0};
    vt[10] = '{mk(F_DOTP, 5'd9),  32'h80808080, 32'h7F7F7F7F, 3'd4, 1'b1, 32'hFFFF0200, 1'b1};
    vt[11] = '{mk(F_DOTP, 5'd10), 32'h80808080, 32'h80808080, 3'd5, 1'b1, 32'h00010000, 1'b1};
    vt[12] = '{mk(F_ACC,  5'd11), 32'h80808080, 32'h7F7F7F7F, 3'd6, 1'b1, 32'hFFFF029E, 1'b1};
    vt[13] = '{mk(F_DOTP, 5'd6) | 32'h02000000, 32'h01020304, 32'h01010101, 3'd7, 1'b0, 32'h0, 1'b0};
    vt[14] = '{mk(3'b011, 5'd6),  32'h01020304, 32'h01010101, 3'd0, 1'b0, 32'h00000000, 1'b0};
    vt[15] = '{mk(F_ACC,  5'd31), 32'h01020304, 32'h01010101, 3'd1, 1'b1, 32'hFFFF02A8, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(issue_ready_o), 32'd0);
    chk("rst_valid", 32'(result_valid_o), 32'd0);
    chk("rst_data", result_data_o, 32'd0);
    chk("rst_id", 32'(result_id_o), 32'd0);
    chk("rst_rd", 32'(result_rd_o), 32'd0);
    chk("rst_we", 32'(result_we_o), 32'd0);
    @(posedge clk);
    #1;
    rst_i          = 1'b0;
    result_ready_i = 1'b1;
    @(negedge clk);
    chk("idle_ready", 32'(issue_ready_o), 32'd1);
    chk("idle_valid", 32'(result_valid_o), 32'd0);
    @(posedge clk);
    #1;

    // Back-to-back vector table
    for (int i = 0; i < NV; i++) begin
      drive_issue(vt[i].instr, vt[i].rs1, vt[i].rs2, vt[i].id, vt[i].acc, vt[i].data,
                  vt[i].consec, $sformatf("vec%0d", i));
    end
    wait_drain("table");

    // Two-cycle latency into an empty FIFO
    drive_issue(mk(F_DOTP, 5'd5), 32'h01020304, 32'h01010101, 3'd2, 1'b1, 32'h0000000A, 1'b0, "lat");
    @(negedge clk);
    chk("lat_c1", 32'(result_valid_o), 32'd0);
    @(negedge clk);
    chk("lat_c2", 32'(result_valid_o), 32'd1);
    wait_drain("lat");

    // Back-pressure: four accepted, fifth blocked until results drain
    result_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = $urandom;
      b = $urandom;
      drive_issue(mk(F_DOTP, 5'(i + 1)), a, b, 3'(i), 1'b1, dotp(a, b), 1'b0, $sformatf("stall%0d", i));
    end
    a5 = $urandom;
    b5 = $urandom;
    issue_valid_i = 1'b1;
    issue_instr_i = mk(F_DOTP, 5'd12);
    issue_rs1_i   = a5;
    issue_rs2_i   = b5;
    issue_id_i    = 3'd4;
    @(negedge clk);
    chk("stall_full", 32'(issue_ready_o), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("stall_hold", 32'(issue_ready_o), 32'd0);
    end
    @(posedge clk);
    #1;
    result_ready_i = 1'b1;
    drive_issue(mk(F_DOTP, 5'd12), a5, b5, 3'd4, 1'b1, dotp(a5, b5), 1'b0, "stall4");
    a = $urandom;
    b = $urandom;
    drive_issue(mk(F_DOTP, 5'd13), a, b, 3'd5, 1'b1, dotp(a, b), 1'b0, "stall5");
    wait_drain("stall");
    chk("stall_cnt", 32'(dut.cnt_q), 32'd0);
    chk("stall_ready_after", 32'(issue_ready_o), 32'd1);

    // Reset with three results pending
    result_ready_i = 1'b0;
    drive_issue(mk(F_ACC, 5'd1), 32'h01020304, 32'h01010101, 3'd5, 1'b1, 32'hFFFF02B2, 1'b0, "prerst0");
    drive_issue(mk(F_ACC, 5'd2), 32'h01020304, 32'h01010101, 3'd6, 1'b1, 32'hFFFF02BC, 1'b0, "prerst1");
    drive_issue(mk(F_ACC, 5'd3), 32'h01020304, 32'h01010101, 3'd7, 1'b1, 32'hFFFF02C6, 1'b0, "prerst2");
    rst_i = 1'b1;
    sbq.delete();
    #1;
    chk("mrst_valid", 32'(result_valid_o), 32'd0);
    chk("mrst_ready", 32'(issue_ready_o), 32'd0);
    chk("mrst_data", result_data_o, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_i          = 1'b0;
    result_ready_i = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("mrst_quiet", 32'(result_valid_o), 32'd0);
    end
    @(posedge clk);
    #1;
    drive_issue(mk(F_ACC, 5'd8), 32'h01020304, 32'h01010101, 3'd0, 1'b1, 32'h0000000A, 1'b0, "postrst");
    wait_drain("postrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cvxif_dotp_copro.md
CVXIF_DOTP_COPRO -- requirements
Module: cvxif_dotp_copro

Interface
REQ-001 The block SHALL have one clock and one reset: the clock is clk_i; the reset is rst_i, asynchronous and active-high.
REQ-002 Parameter XLEN, default 32: operand and result width; only 32 is supported.
REQ-003 Parameter ID_WIDTH, default 3: transaction id width.
REQ-004 Parameter DEPTH, default 4, range 2..8: maximum in-flight plus buffered results.
REQ-005 clk_i  in  1  clock; all state updates on the rising edge.
REQ-006 rst_i  in  1  asynchronous active-high reset.
REQ-007 issue_valid_i  in  1  core offers an instruction.
REQ-008 issue_ready_o  out  1  block can take the offered instruction.
REQ-009 issue_instr_i  in  32  instruction word.
REQ-010 issue_rs1_i, issue_rs2_i  in  XLEN each  source operand values.
REQ-011 issue_id_i  in  ID_WIDTH  transaction id.
REQ-012 issue_accept_o  out  1  instruction is recognised; valid while issue_valid_i=1.
REQ-013 issue_writeback_o  out  1  instruction will return a result; equals issue_accept_o.
REQ-014 result_valid_o  out  1  result available.
REQ-015 result_ready_i  in  1  core takes the result.
REQ-016 result_data_o  out  XLEN  result value.
REQ-017 result_id_o  out  ID_WIDTH  id of the result.
REQ-018 result_rd_o  out  5  destination register.
REQ-019 result_we_o  out  1  write enable; 1 when result_rd_o != 0.

Function
REQ-020 Recognised encodings: opcode[6:0]=0001011 and funct7=0000000. funct3=000 is DOTP4, 001 is DOTP4ACC, 010 is ACCCLR; rd=instr[11:7].
REQ-021 Any other encoding SHALL drive issue_accept_o=0 in the same cycle, still complete the handshake, and produce no result and no state change.
REQ-022 DOTP4: result = sign-extended sum of four signed int8 products rs1[8k+7:8k]*rs2[8k+7:8k], k=0..3, computed modulo 2^32.
REQ-023 DOTP4ACC: acc = acc + DOTP4 value, modulo 2^32; result = new acc.
REQ-024 ACCCLR: acc = 0; result = 0.
REQ-025 Issue handshake: an instruction transfers when issue_valid_i && issue_ready_o.
REQ-026 Result handshake: a result transfers when result_valid_o && result_ready_i.
REQ-027 Once result_valid_o=1, result_data_o, result_id_o, result_rd_o and result_we_o SHALL be held stable until the result transfers.
REQ-028 Pipeline stage S1 SHALL register the four 16-bit products plus id, rd, op and valid; no flow control applies inside S1/S2.
REQ-029 Pipeline stage S2 SHALL perform the adder tree and the accumulator update, then write the result into a result FIFO of DEPTH entries.
REQ-030 Latency: result_valid_o=1 exactly 2 cycles after the issue handshake when the FIFO is empty.
REQ-031 A counter cnt SHALL track accepted instructions in S1, S2 and the FIFO.
REQ-032 issue_ready_o = (cnt < DEPTH) || (result_valid_o && result_ready_i).
REQ-033 Accepted issue without result transfer: cnt+1; result transfer without accepted issue: cnt-1; both in one cycle: cnt unchanged.
REQ-034 Since cnt accounts for S1/S2, FIFO overflow SHALL be impossible; an assertion SHALL check cnt <= DEPTH.
REQ-035 Throughput: one instruction per cycle sustained while result_ready_i=1 and DEPTH >= 3.
REQ-036 Back-to-back DOTP4ACC SHALL chain correctly with no stall, since acc is read and written only in S2.
REQ-037 FIFO pointers SHALL wrap modulo DEPTH.
REQ-038 Results SHALL leave in issue order.

Reset
REQ-039 While rst_i=1, and after it, the block SHALL hold: acc=0, cnt=0, FIFO empty, S1/S2 valid=0, result_valid_o=0, result_data_o=0, result_id_o=0, result_rd_o=0, result_we_o=0.
REQ-040 While rst_i=1, issue_ready_o=0.
REQ-041 Reset asserted mid-operation SHALL discard every in-flight and buffered result; no result SHALL appear after reset deassertion.

Verification
REQ-042 DOTP4, rs1=0x01020304, rs2=0x01010101, rd=5, id=2, result_ready_i=1 -> 2 cycles later result_data_o=0x0000000A, rd=5, id=2, we=1.
REQ-043 DOTP4, rs1=0xFF807F01, rs2=0x01020304 -> result_data_o=0x00000080; same operands with rd=0 -> we=0.
REQ-044 ACCCLR, then three DOTP4ACC back-to-back with rs1=0x01020304, rs2=0x01010101 -> results 10, 20, 30 on consecutive cycles.
REQ-045 result_ready_i=0 with DEPTH=4, issue 6 DOTP4 -> issue_ready_o=0 after 4 accepted; raise result_ready_i -> all 6 results in order, cnt returns to 0.
REQ-046 Unrecognised opcode 0x00000033 -> issue_accept_o=0, handshake completes, no result, acc unchanged.
REQ-047 rst_i pulsed with 3 results pending -> result_valid_o=0 immediately; next DOTP4ACC after ACCCLR-free start returns the DOTP4 value (acc=0).
